// File: rtl/fc_layer.sv
// Fully-connected layer engine: LANES MACs per cycle against a 1-cycle weight port,
// with bias preload, arithmetic-shift requantisation, optional ReLU and output saturation.
module fc_layer #(
    parameter int IN_SIZE  = 1568,
    parameter int OUT_SIZE = 128,
    parameter int LANES    = 8,
    parameter int DATA_W   = 32,
    parameter int W_W      = 8,
    parameter int ACC_W    = 48,
    parameter int SHIFT    = 0,
    parameter int RELU_EN  = 1,
    localparam int CHUNKS  = (IN_SIZE + LANES - 1) / LANES,
    localparam int AW      = (OUT_SIZE * CHUNKS > 1) ? $clog2(OUT_SIZE * CHUNKS) : 1,
    localparam int NW      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [IN_SIZE*DATA_W-1:0]    in_vec,
    input  logic [OUT_SIZE*DATA_W-1:0]   biases,
    output logic                         w_rd_en,
    output logic [AW-1:0]                w_addr,
    input  logic [LANES*W_W-1:0]         w_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [NW-1:0]                out_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PW = DATA_W + W_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_WAIT  = 3'd6;

    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    logic [2:0]               state;
    logic [NW-1:0]            neuron;
    logic [CW-1:0]            chunk;
    logic [AW-1:0]            addr;
    logic signed [ACC_W-1:0]  acc;
    logic                     rd_vld;
    logic [CW-1:0]            rd_chunk;

    logic [LANES*DATA_W-1:0]  xs [CHUNKS];
    logic signed [DATA_W-1:0] bias_a [OUT_SIZE];

    // Pad the input to whole chunks with zeros so tail lanes never contribute.
    for (genvar c = 0; c < CHUNKS; c++) begin : g_chunk
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            if (c * LANES + k < IN_SIZE) begin : g_live
                assign xs[c][k*DATA_W +: DATA_W] =
                    in_vec[(c*LANES+k)*DATA_W +: DATA_W];
            end else begin : g_pad
                assign xs[c][k*DATA_W +: DATA_W] = '0;
            end
        end
    end

    for (genvar n = 0; n < OUT_SIZE; n++) begin : g_bias
        assign bias_a[n] = biases[n*DATA_W +: DATA_W];
    end

    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [ACC_W-1:0]  acc_fin;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] xk;
    logic signed [W_W-1:0]    wk;
    logic signed [PW-1:0]     prod;
    logic [DATA_W-1:0]        res;

    always_comb begin
        mac_sum = '0;
        xk      = '0;
        wk      = '0;
        prod    = '0;
        for (int k = 0; k < LANES; k++) begin
            xk      = xs[rd_chunk][k*DATA_W +: DATA_W];
            wk      = w_rdata[k*W_W +: W_W];
            prod    = PW'(xk) * PW'(wk);
            mac_sum = mac_sum + ACC_W'(prod);
        end
        if (!rd_vld) mac_sum = '0;
    end

    assign acc_fin = acc + mac_sum;
    assign shifted = acc_fin >>> SHIFT;

    always_comb begin
        if (RELU_EN != 0 && shifted[ACC_W-1]) res = '0;
        else if (shifted > SAT_HI)            res = SAT_HI[DATA_W-1:0];
        else if (shifted < SAT_LO)            res = SAT_LO[DATA_W-1:0];
        else                                  res = shifted[DATA_W-1:0];
    end

    // Weight words are requested in strict address order, so a running
    // counter equals neuron*CHUNKS+chunk without a multiplier.
    assign w_rd_en = (state == S_MAC);
    assign w_addr  = addr;
    assign busy    = (state != S_IDLE) && (state != S_WAIT);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            neuron    <= '0;
            chunk     <= '0;
            addr      <= '0;
            acc       <= '0;
            rd_vld    <= 1'b0;
            rd_chunk  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            rd_vld   <= (state == S_MAC);
            rd_chunk <= chunk;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        neuron <= '0;
                        addr   <= '0;
                        state  <= S_INIT;
                    end
                end
                S_INIT: begin
                    acc   <= ACC_W'(bias_a[neuron]);
                    chunk <= '0;
                    state <= S_MAC;
                end
                S_MAC: begin
                    acc  <= acc_fin;
                    addr <= addr + AW'(1);
                    if (chunk == CW'(CHUNKS - 1)) state <= S_DRAIN;
                    else chunk <= chunk + CW'(1);
                end
                S_DRAIN: begin
                    acc       <= acc_fin;
                    out_data  <= res;
                    out_idx   <= neuron;
                    out_valid <= 1'b1;
                    state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (neuron == NW'(OUT_SIZE - 1)) begin
                            state <= S_DONE;
                        end else begin
                            neuron <= neuron + NW'(1);
                            state  <= S_INIT;
                        end
                    end
                end
                S_DONE: state <= S_WAIT;
                S_WAIT: if (!start) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer: small 10x3 layer plus a 16-bit shift/saturate instance,
// each scenario in its own task with hand-computed expectations.
module tb_fc_layer;

    localparam int IN_SIZE  = 10;
    localparam int OUT_SIZE = 3;
    localparam int LANES    = 4;
    localparam int DATA_W   = 32;
    localparam int W_W      = 8;
    localparam int AW       = 4;
    localparam int NW       = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b1;
    logic [IN_SIZE*DATA_W-1:0]  in_vec;
    logic [OUT_SIZE*DATA_W-1:0] biases;
    logic                       w_rd_en;
    logic [AW-1:0]              w_addr;
    logic [LANES*W_W-1:0]       w_rdata = '0;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [NW-1:0]              out_idx;
    logic                       busy;
    logic                       done;

    logic        start_b = 1'b0;
    logic [63:0] in_vec_b;
    logic [31:0] biases_b;
    logic        w_rd_en_b;
    logic [0:0]  w_addr_b;
    logic [31:0] w_rdata_b = '0;
    logic        out_valid_b;
    logic [15:0] out_data_b;
    logic [0:0]  out_idx_b;
    logic        busy_b;
    logic        done_b;

    logic [31:0] rom_a [16];
    logic [31:0] rom_b [2];

    int n_vec = 0;
    int n_err = 0;
    int exp_d [3] = '{55, 0, 60};
    int hs_idx [8];
    int hs_data [8];
    int n_hs, done_cyc, done_pulses, first_rd;
    int rd_in_emit, unstable, stall_seen, post_busy;

    always #5 clk = ~clk;

    always @(posedge clk) if (w_rd_en) w_rdata <= rom_a[w_addr];
    always @(posedge clk) if (w_rd_en_b) w_rdata_b <= rom_b[w_addr_b];

    fc_layer #(
        .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .LANES(LANES),
        .DATA_W(DATA_W), .W_W(W_W), .ACC_W(48), .SHIFT(0), .RELU_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_vec(in_vec), .biases(biases),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    fc_layer #(
        .IN_SIZE(4), .OUT_SIZE(2), .LANES(4),
        .DATA_W(16), .W_W(8), .ACC_W(32), .SHIFT(2), .RELU_EN(0)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .in_vec(in_vec_b), .biases(biases_b),
        .w_rd_en(w_rd_en_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
        .out_valid(out_valid_b), .out_ready(1'b1),
        .out_data(out_data_b), .out_idx(out_idx_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic load_rom(input bit mask);
        for (int a = 0; a < 16; a++) begin
            if (a >= 9)                  rom_a[a] = 32'hFFFF_FFFF;
            else if (mask && a % 3 == 2) rom_a[a] = 32'h7F7F_0101;
            else                         rom_a[a] = 32'h0101_0101;
        end
    endtask

    // Start a run on dut and log handshakes and timing; cycle 1 is INIT.
    task automatic do_run(input int stall_idx, input int stall_len,
                          input bit hold, input bit repulse);
        int  stall_left;
        bit  stalled;
        logic [DATA_W-1:0] hd;
        logic [NW-1:0]     hi;
        stall_left = stall_len;
        stalled = 1'b0;
        hd = '0;
        hi = '0;
        for (int i = 0; i < 8; i++) begin
            hs_idx[i]  = -1;
            hs_data[i] = -99999;
        end
        n_hs = 0; done_cyc = -1; done_pulses = 0; first_rd = -1;
        rd_in_emit = 0; unstable = 0; stall_seen = 0; post_busy = 0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            start = hold || (repulse && cyc == 8);
            if (w_rd_en && first_rd < 0) first_rd = cyc;
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc && (busy || w_rd_en)) post_busy++;
            if (out_valid && w_rd_en) rd_in_emit++;
            if (stalled && (out_data !== hd || out_idx !== hi || !out_valid)) unstable++;
            hd = out_data;
            hi = out_idx;
            if (out_valid && int'(out_idx) == stall_idx && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                stall_seen++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready && n_hs < 8) begin
                hs_idx[n_hs]  = int'(out_idx);
                hs_data[n_hs] = int'($signed(out_data));
                n_hs++;
            end
            stalled = out_valid && !out_ready;
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec += 7;
        if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        if (done !== 1'b0)      begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        if (w_rd_en !== 1'b0)   begin n_err++; $display("FAIL rst_rden: got %b want 0", w_rd_en); end
        if (out_data !== '0)    begin n_err++; $display("FAIL rst_data: got %0h want 0", out_data); end
        if (out_idx !== '0)     begin n_err++; $display("FAIL rst_idx: got %0d want 0", out_idx); end
        if (w_addr !== '0)      begin n_err++; $display("FAIL rst_addr: got %0d want 0", w_addr); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        load_rom(1'b0);
        do_run(-1, 0, 1'b0, 1'b0);
        n_vec += 4;
        if (n_hs !== 3)        begin n_err++; $display("FAIL basic_hs: got %0d want 3", n_hs); end
        if (done_cyc !== 19)   begin n_err++; $display("FAIL basic_done_cyc: got %0d want 19", done_cyc); end
        if (first_rd !== 2)    begin n_err++; $display("FAIL basic_first_rd: got %0d want 2", first_rd); end
        if (done_pulses !== 1) begin n_err++; $display("FAIL basic_pulses: got %0d want 1", done_pulses); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (hs_idx[i] !== i || hs_data[i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL basic_out%0d: got (%0d,%0d) want (%0d,%0d)",
                         i, hs_idx[i], hs_data[i], i, exp_d[i]);
            end
        end
    endtask

    task automatic test_mask;
        load_rom(1'b1);
        do_run(-1, 0, 1'b0, 1'b0);
        n_vec += 2;
        if (n_hs !== 3)      begin n_err++; $display("FAIL mask_hs: got %0d want 3", n_hs); end
        if (done_cyc !== 19) begin n_err++; $display("FAIL mask_done_cyc: got %0d want 19", done_cyc); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (hs_idx[i] !== i || hs_data[i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL mask_out%0d: got (%0d,%0d) want (%0d,%0d)",
                         i, hs_idx[i], hs_data[i], i, exp_d[i]);
            end
        end
        load_rom(1'b0);
    endtask

    task automatic test_backpressure;
        do_run(1, 5, 1'b0, 1'b0);
        n_vec += 5;
        if (stall_seen !== 5) begin n_err++; $display("FAIL bp_stalls: got %0d want 5", stall_seen); end
        if (unstable !== 0)   begin n_err++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        if (rd_in_emit !== 0) begin n_err++; $display("FAIL bp_rden: got %0d reads want 0", rd_in_emit); end
        if (done_cyc !== 24)  begin n_err++; $display("FAIL bp_done_cyc: got %0d want 24", done_cyc); end
        if (n_hs !== 3)       begin n_err++; $display("FAIL bp_hs: got %0d want 3", n_hs); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (hs_idx[i] !== i || hs_data[i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL bp_out%0d: got (%0d,%0d) want (%0d,%0d)",
                         i, hs_idx[i], hs_data[i], i, exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_vec += 3;
        if (busy !== 1'b1)     begin n_err++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
        if (w_rd_en !== 1'b1)  begin n_err++; $display("FAIL mid_pre_rden: got %b want 1", w_rd_en); end
        if (int'(out_data) !== 55) begin n_err++; $display("FAIL mid_pre_data: got %0d want 55", out_data); end
        reset = 1'b1;
        @(negedge clk);
        n_vec += 7;
        if (busy !== 1'b0)      begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        if (done !== 1'b0)      begin n_err++; $display("FAIL mid_done: got %b want 0", done); end
        if (w_rd_en !== 1'b0)   begin n_err++; $display("FAIL mid_rden: got %b want 0", w_rd_en); end
        if (out_data !== '0)    begin n_err++; $display("FAIL mid_data: got %0h want 0", out_data); end
        if (out_idx !== '0)     begin n_err++; $display("FAIL mid_idx: got %0d want 0", out_idx); end
        if (w_addr !== '0)      begin n_err++; $display("FAIL mid_addr: got %0d want 0", w_addr); end
        reset = 1'b0;
        do_run(-1, 0, 1'b0, 1'b0);
        n_vec += 2;
        if (n_hs !== 3)      begin n_err++; $display("FAIL rerun_hs: got %0d want 3", n_hs); end
        if (done_cyc !== 19) begin n_err++; $display("FAIL rerun_done_cyc: got %0d want 19", done_cyc); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (hs_idx[i] !== i || hs_data[i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL rerun_out%0d: got (%0d,%0d) want (%0d,%0d)",
                         i, hs_idx[i], hs_data[i], i, exp_d[i]);
            end
        end
    endtask

    task automatic test_start_hold;
        do_run(-1, 0, 1'b1, 1'b0);
        n_vec += 4;
        if (done_pulses !== 1) begin n_err++; $display("FAIL hold_pulses: got %0d want 1", done_pulses); end
        if (post_busy !== 0)   begin n_err++; $display("FAIL hold_wait: got %0d busy cycles want 0", post_busy); end
        if (done_cyc !== 19)   begin n_err++; $display("FAIL hold_done_cyc: got %0d want 19", done_cyc); end
        if (n_hs !== 3)        begin n_err++; $display("FAIL hold_hs: got %0d want 3", n_hs); end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL hold_idle: got %b want 0", busy); end
    endtask

    task automatic test_start_repulse;
        do_run(-1, 0, 1'b0, 1'b1);
        n_vec += 3;
        if (done_pulses !== 1) begin n_err++; $display("FAIL rep_pulses: got %0d want 1", done_pulses); end
        if (done_cyc !== 19)   begin n_err++; $display("FAIL rep_done_cyc: got %0d want 19", done_cyc); end
        if (n_hs !== 3)        begin n_err++; $display("FAIL rep_hs: got %0d want 3", n_hs); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (hs_idx[i] !== i || hs_data[i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL rep_out%0d: got (%0d,%0d) want (%0d,%0d)",
                         i, hs_idx[i], hs_data[i], i, exp_d[i]);
            end
        end
    endtask

    // Neuron 0: bias -4001, zero weights -> -4001>>>2 = -1001.
    // Neuron 1: 16384*64 = 2^20 -> 2^18, saturates to 32767.
    task automatic test_shift_sat;
        int got_d [2];
        int got_i [2];
        int nh;
        int dc;
        got_d = '{-99999, -99999};
        got_i = '{-1, -1};
        nh = 0;
        dc = -1;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (out_valid_b && nh < 2) begin
                got_i[nh] = int'(out_idx_b);
                got_d[nh] = int'($signed(out_data_b));
                nh++;
            end
            if (done_b && dc < 0) dc = cyc;
            if (dc >= 0) break;
        end
        n_vec += 4;
        if (nh !== 2) begin n_err++; $display("FAIL shift_hs: got %0d want 2", nh); end
        if (dc !== 9) begin n_err++; $display("FAIL shift_done_cyc: got %0d want 9", dc); end
        if (got_i[0] !== 0 || got_d[0] !== -1001) begin
            n_err++;
            $display("FAIL shift_neg: got (%0d,%0d) want (0,-1001)", got_i[0], got_d[0]);
        end
        if (got_i[1] !== 1 || got_d[1] !== 32767) begin
            n_err++;
            $display("FAIL shift_sat: got (%0d,%0d) want (1,32767)", got_i[1], got_d[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < IN_SIZE; i++) in_vec[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
        biases[0 +: 32]  = 32'sd0;
        biases[32 +: 32] = -32'sd100;
        biases[64 +: 32] = 32'sd5;
        in_vec_b = {16'd0, 16'd0, 16'd0, 16'd16384};
        biases_b = {16'd0, 16'hF05F};
        rom_b[0] = 32'h0000_0000;
        rom_b[1] = 32'h0000_0040;
        load_rom(1'b0);

        test_reset();
        test_basic();
        test_mask();
        test_backpressure();
        test_reset_mid();
        test_start_hold();
        test_start_repulse();
        test_shift_sat();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fc_layer.md
# fc_layer

Parametrised fully-connected layer engine for the quickdraw CNN datapath. It computes OUT_SIZE neurons over a flattened IN_SIZE input vector, processing LANES multiply-accumulates per cycle. Weights are fetched from an external synchronous ROM/RAM port rather than a flat array. Each neuron's result gets an optional right-shift requantisation, optional ReLU and output saturation, and is emitted on a valid/ready stream. It is the generic replacement for the fixed-size FC stages after pool2, and is intended for FC1, FC2 and the classifier head.

## Interface
- IN_SIZE, 1568: input vector length.
- OUT_SIZE, 128: number of output neurons.
- LANES, 8: MACs per cycle; CHUNKS = ceil(IN_SIZE/LANES).
- DATA_W, 32: signed width of input activations, biases and outputs.
- W_W, 8: signed weight width.
- ACC_W, 48: internal accumulator width; must be ≥ DATA_W+W_W.
- SHIFT, 0: arithmetic right shift applied to the final accumulator.
- RELU_EN, 1: 1 clamps negative results to 0; 0 passes them through.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level request; sampled only in IDLE.
- in_vec  in  IN_SIZE×DATA_W  signed flattened input; must be stable from the start edge until done.
- biases  in  OUT_SIZE×DATA_W  signed biases; same stability rule as in_vec.
- w_rd_en  out  1  weight read strobe.
- w_addr  out  clog2(OUT_SIZE*CHUNKS)  word address = neuron*CHUNKS + chunk.
- w_rdata  in  LANES×W_W  weight word, returned exactly 1 cycle after w_rd_en. Lane k sits at bits [k*W_W +: W_W] and pairs with in_vec[chunk*LANES+k].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  signed neuron result.
- out_idx  out  clog2(OUT_SIZE)  neuron index of out_data.
- busy  out  1  high in every state except IDLE and WAIT_START_LOW.
- done  out  1  one-cycle pulse after the last neuron is accepted.

## Operation
- States: IDLE, INIT, MAC, DRAIN, EMIT, DONE, WAIT_START_LOW.
- IDLE: if start=1, clear neuron to 0 and go to INIT. If start=0, stay in IDLE.
- INIT (1 cycle):
  - acc ← sign-extended biases[neuron].
  - chunk ← 0.
  - Go to MAC.
- MAC (CHUNKS cycles):
  - Each cycle: w_rd_en=1 and w_addr=neuron*CHUNKS+chunk; chunk increments.
  - The word read in the previous MAC cycle is accumulated: acc += Σ in_vec[i]*w[k], with products sign-extended to ACC_W.
  - Lanes with index i ≥ IN_SIZE contribute 0, whatever their w_rdata value.
  - After chunk CHUNKS-1 is issued, go to DRAIN.
- DRAIN (1 cycle):
  - w_rd_en=0. The last word is accumulated.
  - The result r is registered into out_data:
    - s = (acc_final >>> SHIFT);
    - if RELU_EN and s<0, s = 0;
    - saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_idx ← neuron; out_valid ← 1. Go to EMIT.
- EMIT: hold out_valid, out_data and out_idx until out_valid&&out_ready.
  - On that handshake, out_valid ← 0.
  - If neuron==OUT_SIZE-1, go to DONE; otherwise neuron++ and go to INIT.
- DONE (1 cycle): done=1. Go to WAIT_START_LOW.
- WAIT_START_LOW: stay while start=1; go to IDLE when start=0.
- Accumulator overflow wraps modulo 2^ACC_W. No internal saturation is applied; only the output is saturated.
- start asserted while busy is ignored.

## Timing
- Reset values (also on reset asserted mid-operation, which takes effect on the next edge):
  - state = IDLE; out_valid, done, w_rd_en, busy = 0.
  - out_data, out_idx, w_addr, neuron, chunk, acc = 0.
  - Any pending weight read is discarded.
- Start latency: start is sampled high at edge t, so INIT occupies cycle t+1 and the first w_rd_en is in cycle t+2.
- Per-neuron cost with out_ready held high: 1 (INIT) + CHUNKS (MAC) + 1 (DRAIN) + 1 (EMIT) = CHUNKS+3 cycles.
- Total from start edge to done pulse: 1 + OUT_SIZE*(CHUNKS+3) cycles. With defaults that is 1 + 128*199 = 25473 cycles.
- Backpressure: each cycle out_ready is low in EMIT adds one cycle. No weight reads are issued while in EMIT.
- out_data and out_idx change only on the DRAIN→EMIT transition.
- Exactly OUT_SIZE handshakes occur per run, in strictly ascending out_idx order.

## Test plan
- Basic run, IN_SIZE=10, LANES=4, OUT_SIZE=3, SHIFT=0, RELU_EN=1:
  - Stimulus: in_vec=1..10, all weights=1, biases={0,-100,5}, out_ready=1.
  - Required: outputs (idx,data) = (0,55), (1,0), (2,60).
  - Required: done is asserted exactly 1+3*6=19 cycles after the start edge.
- Partial-chunk masking: same setup, but lanes 2–3 of the last word carry 0x7F.
  - Required: outputs are unchanged.
- Shift, saturation and ReLU bypass, DATA_W=16, SHIFT=2, RELU_EN=0:
  - A neuron with acc=-4001 must output -1001.
  - A neuron with acc=2^20 must output 32767.
- Backpressure: hold out_ready low for 5 cycles on neuron 1.
  - Required: out_data and out_idx stay stable for those cycles, w_rd_en=0 throughout, and the total run is 5 cycles longer.
- Reset mid-MAC on neuron 1:
  - Required: the next cycle shows IDLE with all outputs 0.
  - Required: a fresh start then reproduces the basic-run results exactly.
- Start handling:
  - Hold start high through the whole run: exactly one done pulse, then the block stays in WAIT_START_LOW until start falls.
  - Re-pulse start mid-run: ignored.
